// File: rtl/irq_pkg.sv
// irq_pkg: register offsets, STAT bit positions and vector width for irq_nest_ctrl
package irq_pkg;
  localparam logic [11:0] OFF_RA   = 12'hfff;
  localparam logic [11:0] OFF_ISR  = 12'hffe;
  localparam logic [11:0] OFF_IMR  = 12'hffd;
  localparam logic [11:0] OFF_EDGE = 12'hffc;
  localparam logic [11:0] OFF_VEC  = 12'hffb;
  localparam logic [11:0] OFF_STAT = 12'hffa;
  localparam int STAT_UNDER = 31;
  localparam int STAT_OVER  = 30;
  localparam int VEC_W      = 5;
endpackage

// File: rtl/irq_nest_ctrl_if.sv
// irq_nest_ctrl_if: data-bus slave port of the nested interrupt controller
interface irq_nest_ctrl_if;
  logic        strobe;
  logic        rw;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  modport master(output strobe, rw, d_addr, d_wdata, input d_rdata, d_rvalid);
  modport slave(input strobe, rw, d_addr, d_wdata, output d_rdata, d_rvalid);
endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-first priority encoder
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]     req,
  output logic             any,
  output logic [VEC_W-1:0] idx
);
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) idx = VEC_W'(i);
  end
endmodule

// File: rtl/irq_nest_ctrl.sv
// irq_nest_ctrl: nested external-interrupt controller with RA/IMR frame stack on the data bus
module irq_nest_ctrl
  import irq_pkg::*;
#(
  parameter int          IRQ_COUNT  = 32,
  parameter int          DEPTH_BITS = 2,
  parameter logic [19:0] BASE_PAGE  = 20'hfffff,
  parameter logic [31:0] IMR_RESET  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IRQ_COUNT-1:0] irq,
  irq_nest_ctrl_if.slave       bus,
  output logic                 trap,
  output logic [VEC_W-1:0]     vector
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int N = IRQ_COUNT;
  logic [N-1:0] isr, edge_mode, irq_q, pend, clr, isr_n;
  logic [N-1:0] imr [DEPTH];
  logic [31:0] ra [DEPTH];
  logic [DEPTH_BITS-1:0] depth, dp1;
  logic err_under, err_over, sel, rd, wr, any;
  logic [11:0] off;
  logic [VEC_W-1:0] idx;
  logic [31:0] rd_val;
  irq_prio_enc #(.N(N)) u_enc (.req(pend), .any(any), .idx(idx));
  always_comb begin
    sel = bus.strobe && bus.d_addr[31:12] == BASE_PAGE;
    off = bus.d_addr[11:0];
    rd = sel && !bus.rw;
    wr = sel && bus.rw;
    dp1 = depth + 1'b1;
    pend = isr & imr[depth];
    clr = (wr && off == OFF_ISR) ? bus.d_wdata[N-1:0] & edge_mode : '0;
    // a new edge in the same cycle as its W1C survives the clear
    isr_n = (edge_mode & ((isr & ~clr) | (irq & ~irq_q))) | (~edge_mode & irq);
    rd_val = off == OFF_RA   ? (depth == '0 ? 32'h0 : ra[depth]) :
             off == OFF_ISR  ? 32'(isr) :
             off == OFF_IMR  ? 32'(imr[depth]) :
             off == OFF_EDGE ? 32'(edge_mode) :
             off == OFF_VEC  ? {trap, 26'b0, vector} :
             off == OFF_STAT ? {err_under, err_over, 30'(depth)} : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      isr <= '0;
      edge_mode <= '0;
      irq_q <= '0;
      depth <= '0;
      err_under <= 1'b0;
      err_over <= 1'b0;
      trap <= 1'b0;
      vector <= '0;
      bus.d_rvalid <= 1'b0;
      bus.d_rdata <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ra[i] <= '0;
        imr[i] <= i == 0 ? IMR_RESET[N-1:0] : '0;
      end
    end else begin
      irq_q <= irq;
      isr <= isr_n;
      trap <= any;
      if (any) vector <= idx;
      bus.d_rvalid <= rd;
      if (rd) bus.d_rdata <= rd_val;
      if (rd && off == OFF_RA) begin
        if (depth == '0) err_under <= 1'b1;
        else depth <= depth - 1'b1;
      end
      if (wr && off == OFF_RA) begin
        if (&depth) err_over <= 1'b1;
        else begin
          ra[dp1] <= bus.d_wdata;
          imr[dp1] <= '0;
          depth <= dp1;
        end
      end
      if (wr && off == OFF_IMR) imr[depth] <= bus.d_wdata[N-1:0];
      if (wr && off == OFF_EDGE) edge_mode <= bus.d_wdata[N-1:0];
      if (wr && off == OFF_STAT) begin
        if (bus.d_wdata[STAT_UNDER]) err_under <= 1'b0;
        if (bus.d_wdata[STAT_OVER]) err_over <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_irq_nest_ctrl.sv
// tb_irq_nest_ctrl: directed table plus randomized traffic against a queue-based reference model
module tb_irq_nest_ctrl;
  import irq_pkg::*;
  localparam logic [19:0] PAGE = 20'hfffff;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [31:0] irq = '0;
  logic trap;
  logic [4:0] vector;
  int total = 0, bad = 0;
  irq_nest_ctrl_if bus ();
  irq_nest_ctrl #(.IRQ_COUNT(32), .DEPTH_BITS(2), .BASE_PAGE(PAGE), .IMR_RESET(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .irq(irq), .bus(bus.slave), .trap(trap), .vector(vector));
  always #5 clk = ~clk;
  logic [31:0] m_isr, m_edge, m_irq_q, m_rdata;
  logic m_rvalid, m_trap, m_under, m_over;
  logic [4:0] m_vec;
  logic [31:0] m_ra[$], m_imr[$];
  function automatic void model_step(logic rn, logic [31:0] iv, logic stb, logic rw, logic [31:0] a, logic [31:0] wd);
    logic [31:0] pend, clr, ne, nisr;
    logic sel;
    int d;
    if (!rn) begin
      m_isr = 0; m_edge = 0; m_irq_q = 0; m_rdata = 0; m_rvalid = 0; m_trap = 0; m_vec = 0;
      m_under = 0; m_over = 0; m_ra = {32'h0}; m_imr = {32'h0};
      return;
    end
    d = m_imr.size() - 1;
    pend = m_isr & m_imr[d];
    sel = stb && a[31:12] == PAGE;
    clr = 0;
    ne = m_edge;
    m_rvalid = sel && !rw;
    if (sel && !rw)
      case (a[11:0])
        OFF_RA: if (d == 0) begin m_rdata = 0; m_under = 1; end
                else begin m_rdata = m_ra.pop_back(); void'(m_imr.pop_back()); end
        OFF_ISR:  m_rdata = m_isr;
        OFF_IMR:  m_rdata = m_imr[d];
        OFF_EDGE: m_rdata = m_edge;
        OFF_VEC:  m_rdata = {m_trap, 26'b0, m_vec};
        OFF_STAT: m_rdata = {m_under, m_over, 30'(d)};
        default:  m_rdata = 0;
      endcase
    if (sel && rw)
      case (a[11:0])
        OFF_RA: if (d == 3) m_over = 1; else begin m_ra.push_back(wd); m_imr.push_back(0); end
        OFF_ISR:  clr = wd & m_edge;
        OFF_IMR:  m_imr[d] = wd;
        OFF_EDGE: ne = wd;
        OFF_STAT: begin if (wd[31]) m_under = 0; if (wd[30]) m_over = 0; end
        default: ;
      endcase
    for (int i = 0; i < 32; i++)
      nisr[i] = m_edge[i] ? ((m_isr[i] & ~clr[i]) | (iv[i] & ~m_irq_q[i])) : iv[i];
    m_isr = nisr;
    m_edge = ne;
    m_irq_q = iv;
    if (pend != 0) m_vec = 5'($countones((pend & -pend) - 32'd1));
    m_trap = pend != 0;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic step(logic rn, logic [31:0] iv, logic stb, logic rw, logic [31:0] a, logic [31:0] wd);
    reset_n = rn; irq = iv; bus.strobe = stb; bus.rw = rw; bus.d_addr = a; bus.d_wdata = wd;
    model_step(rn, iv, stb, rw, a, wd);
    @(negedge clk);
    chk("trap", 32'(trap), 32'(m_trap));
    chk("vector", 32'(vector), 32'(m_vec));
    chk("rvalid", 32'(bus.d_rvalid), 32'(m_rvalid));
    chk("rdata", bus.d_rdata, m_rdata);
  endtask
  typedef struct {
    logic [31:0] irq;
    logic stb, rw;
    logic [11:0] off;
    logic [31:0] wd;
    logic crd;
    logic [31:0] erd;
    logic ctr, etr;
  } row_t;
  function automatic row_t rd_row(logic [11:0] off, logic [31:0] erd, logic ctr = 0, logic etr = 0, logic [31:0] iv = 0);
    return '{iv, 1'b1, 1'b0, off, 32'h0, 1'b1, erd, ctr, etr};
  endfunction
  function automatic row_t wr_row(logic [11:0] off, logic [31:0] wd, logic [31:0] iv = 0);
    return '{iv, 1'b1, 1'b1, off, wd, 1'b0, 32'h0, 1'b0, 1'b0};
  endfunction
  function automatic row_t idle_row(logic [31:0] iv, logic ctr = 0, logic etr = 0);
    return '{iv, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, ctr, etr};
  endfunction
  row_t tbl[$];
  initial begin
    bus.strobe = 0; bus.rw = 0; bus.d_addr = 0; bus.d_wdata = 0;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    tbl.push_back(rd_row(OFF_STAT, 32'h0, 1, 0));
    tbl.push_back(rd_row(OFF_ISR, 32'h0));
    tbl.push_back(rd_row(OFF_IMR, 32'h0));
    tbl.push_back(wr_row(OFF_IMR, 32'h11));
    tbl.push_back(wr_row(OFF_EDGE, 32'h11));
    tbl.push_back(idle_row(32'h10, 1, 0));
    tbl.push_back(idle_row(32'h0, 1, 1));
    tbl.push_back(idle_row(32'h1, 1, 1));
    tbl.push_back(idle_row(32'h0, 1, 1));
    tbl.push_back(rd_row(OFF_VEC, 32'h8000_0000));
    tbl.push_back(wr_row(OFF_ISR, 32'h1));
    tbl.push_back(idle_row(32'h0));
    tbl.push_back(rd_row(OFF_VEC, 32'h8000_0004));
    tbl.push_back(wr_row(OFF_ISR, 32'h10));
    tbl.push_back(idle_row(32'h0));
    tbl.push_back(rd_row(OFF_VEC, 32'h0000_0004, 1, 0));
    tbl.push_back(idle_row(32'h10));
    tbl.push_back(idle_row(32'h0, 1, 1));
    tbl.push_back(wr_row(OFF_RA, 32'h100));
    tbl.push_back(rd_row(OFF_IMR, 32'h0, 1, 0));
    tbl.push_back(wr_row(OFF_RA, 32'h200));
    tbl.push_back(rd_row(OFF_RA, 32'h200));
    tbl.push_back(rd_row(OFF_RA, 32'h100));
    tbl.push_back(rd_row(OFF_STAT, 32'h0));
    tbl.push_back(rd_row(OFF_IMR, 32'h11));
    tbl.push_back(idle_row(32'h0, 1, 1));
    tbl.push_back(wr_row(OFF_ISR, 32'h10));
    for (int i = 1; i <= 5; i++) tbl.push_back(wr_row(OFF_RA, 32'(i)));
    tbl.push_back(rd_row(OFF_STAT, 32'h4000_0003));
    tbl.push_back(rd_row(OFF_RA, 32'h3));
    tbl.push_back(rd_row(OFF_RA, 32'h2));
    tbl.push_back(rd_row(OFF_RA, 32'h1));
    tbl.push_back(rd_row(OFF_RA, 32'h0));
    tbl.push_back(rd_row(OFF_STAT, 32'hC000_0000));
    tbl.push_back(wr_row(OFF_STAT, 32'hC000_0000));
    tbl.push_back(rd_row(OFF_STAT, 32'h0));
    tbl.push_back(idle_row(32'h4));
    tbl.push_back(wr_row(OFF_ISR, 32'h4, 32'h4));
    tbl.push_back(rd_row(OFF_ISR, 32'h4, 0, 0, 32'h4));
    tbl.push_back(idle_row(32'h0));
    tbl.push_back(rd_row(OFF_ISR, 32'h0));
    tbl.push_back(wr_row(OFF_EDGE, 32'h19));
    tbl.push_back(wr_row(OFF_IMR, 32'h19));
    tbl.push_back(wr_row(OFF_ISR, 32'h8, 32'h8));
    tbl.push_back(rd_row(OFF_ISR, 32'h8, 1, 1));
    foreach (tbl[k]) begin
      step(1, tbl[k].irq, tbl[k].stb, tbl[k].rw, {PAGE, tbl[k].off}, tbl[k].wd);
      if (tbl[k].crd) chk($sformatf("tbl%0d_rdata", k), bus.d_rdata, tbl[k].erd);
      if (tbl[k].ctr) chk($sformatf("tbl%0d_trap", k), 32'(trap), 32'(tbl[k].etr));
    end
    step(1, 0, 1, 1, {PAGE, OFF_RA}, 32'h55);
    step(0, 0, 1, 0, {PAGE, OFF_ISR}, 0);
    chk("reset_rvalid", 32'(bus.d_rvalid), 32'h0);
    chk("reset_trap", 32'(trap), 32'h0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, {PAGE, OFF_STAT}, 0);
    chk("reset_stat", bus.d_rdata, 32'h0);
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] iv, a;
      logic [11:0] off;
      iv = ($urandom_range(0, 3) == 0) ? irq ^ ($urandom & $urandom & $urandom) : irq;
      case ($urandom_range(0, 7))
        0: off = OFF_RA;
        1: off = OFF_ISR;
        2: off = OFF_IMR;
        3: off = OFF_EDGE;
        4: off = OFF_VEC;
        5: off = OFF_STAT;
        6: off = 12'($urandom);
        default: off = OFF_RA;
      endcase
      a = ($urandom_range(0, 15) == 0) ? {20'($urandom), off} : {PAGE, off};
      step($urandom_range(0, 299) != 0, iv, $urandom_range(0, 2) == 0, 1'($urandom), a, $urandom);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
